// File: rtl/led_pkg.sv
// -----------------------------------------------------------------------------
// led_pkg
// Shared definitions for the note-scroll LED scanner.
//   - state_t      : scanner FSM states (LOAD, SHIFT, BLANK, LATCH, DISPLAY)
//   - NSLOT        : note slots per lane bitmap (also used by the song loader)
//   - SLOT_W       : pixels per slot; the scroll offset runs 0..SLOT_W-1
//   - clamp_offset : limits an incoming offset to the last pixel of a slot
// -----------------------------------------------------------------------------
package led_pkg;

  localparam int NSLOT  = 10;
  localparam int SLOT_W = 7;

  typedef enum logic [2:0] {
    LOAD,
    SHIFT,
    BLANK,
    LATCH,
    DISPLAY
  } state_t;

  function automatic logic [2:0] clamp_offset(input logic [2:0] off, input int slot_w);
    return (int'(off) >= slot_w) ? 3'(slot_w - 1) : off;
  endfunction

endpackage

// File: rtl/led_col_gen.sv
// -----------------------------------------------------------------------------
// led_col_gen
// Walks the note slots across one panel row without a divider: a sub-pixel
// counter runs from the scroll offset up to SLOT_W-1, and each wrap moves on to
// the next slot. The selected lane's snapshot bit is the pixel.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   start         : hold counters at the row start (sub=offset_snap, slot=0)
//   advance       : step to the next column
//   offset_snap   : scroll offset the row starts from
//   lane_blue     : 1 selects the blue snapshot, 0 the red one
//   note_r_snap   : red-lane note snapshot
//   note_b_snap   : blue-lane note snapshot
//   pixel         : note bit for the current column (0 past the last slot)
// -----------------------------------------------------------------------------
module led_col_gen #(
  parameter int NSLOT  = led_pkg::NSLOT,
  parameter int SLOT_W = led_pkg::SLOT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             advance,
  input  logic [2:0]       offset_snap,
  input  logic             lane_blue,
  input  logic [NSLOT-1:0] note_r_snap,
  input  logic [NSLOT-1:0] note_b_snap,
  output logic             pixel
);

  // One spare bit beyond what NSLOT needs, so the slot index can run past the
  // last slot into the dark region instead of wrapping back onto slot 0.
  localparam int SLOT_CW = $clog2(NSLOT + 1) + 1;
  localparam int IDX_W   = (NSLOT > 1) ? $clog2(NSLOT) : 1;

  logic [2:0]         sub;
  logic [SLOT_CW-1:0] slot;
  logic [NSLOT-1:0]   lane_vec;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sub  <= 3'd0;
      slot <= '0;
    end else if (start) begin
      sub  <= offset_snap;
      slot <= '0;
    end else if (advance) begin
      if (sub == 3'(SLOT_W - 1)) begin
        sub <= 3'd0;
        if (slot != '1) slot <= slot + SLOT_CW'(1);
      end else begin
        sub <= sub + 3'd1;
      end
    end
  end

  always_comb begin
    lane_vec = lane_blue ? note_b_snap : note_r_snap;
    pixel    = 1'b0;
    if (slot < SLOT_CW'(NSLOT)) pixel = lane_vec[slot[IDX_W-1:0]];
  end

endmodule

// File: rtl/led_note_scanner.sv
// -----------------------------------------------------------------------------
// led_note_scanner
// Renders the red/blue note lanes as a scrolling strip on a row-scanned RGB LED
// panel: red lane on rows 0..ROWS/2-1, blue lane on the rest. Inputs are
// snapshotted once per frame (LOAD) so a frame never mixes two pictures.
// Per row: SHIFT COLS pixels (sclk low then high, CLK_DIV cycles each), BLANK,
// LATCH, then DISPLAY for HOLD cycles.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   note_R, note_B  : per-slot note bitmaps for the red / blue lane
//   offset          : scroll position inside a slot (clamped to SLOT_W-1)
//   finish          : song-end pulse (used only with FINISH_FLASH_EN)
//   r_data, b_data  : serial pixel data, valid while sclk rises
//   sclk, latch     : panel shift clock and latch strobe
//   oe_n            : panel output enable, active low (low only in DISPLAY)
//   row_addr        : row being displayed
//   frame_done      : one-cycle pulse after the last row's DISPLAY
// Build option:
//   FINISH_FLASH_EN : a finish pulse lights every pixel in its lane colour
//                     for the next three frames.
// -----------------------------------------------------------------------------
module led_note_scanner #(
  parameter int COLS    = 64,
  parameter int ROWS    = 8,
  parameter int NSLOT   = led_pkg::NSLOT,
  parameter int SLOT_W  = led_pkg::SLOT_W,
  parameter int CLK_DIV = 2,
  parameter int HOLD    = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NSLOT-1:0]        note_R,
  input  logic [NSLOT-1:0]        note_B,
  input  logic [2:0]              offset,
  input  logic                    finish,
  output logic                    r_data,
  output logic                    b_data,
  output logic                    sclk,
  output logic                    latch,
  output logic                    oe_n,
  output logic [$clog2(ROWS)-1:0] row_addr,
  output logic                    frame_done
);

  import led_pkg::*;

  localparam int RA_W   = $clog2(ROWS);
  localparam int CA_W   = $clog2(COLS);
  localparam int DIV_W  = $clog2(CLK_DIV + 1);
  localparam int HOLD_W = $clog2(HOLD + 1);

  state_t            state, state_nxt;
  logic [NSLOT-1:0]  note_r_snap, note_b_snap;
  logic [2:0]        offset_snap, gen_offset;
  logic [RA_W-1:0]   row_cnt;
  logic [CA_W-1:0]   col_cnt;
  logic              phase;       // 0: sclk low half, 1: sclk high half
  logic [DIV_W-1:0]  div_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              div_last, hold_last, row_last, col_last, advance;
  logic              lane_blue, col_bit, flash_lit, pixel;

  assign div_last  = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign hold_last = (hold_cnt == HOLD_W'(HOLD - 1));
  assign row_last  = (row_cnt == RA_W'(ROWS - 1));
  assign col_last  = (col_cnt == CA_W'(COLS - 1));
  assign advance   = (state == SHIFT) && phase && div_last;
  assign lane_blue = (row_cnt >= RA_W'(ROWS / 2));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first; a path that left
  // state_nxt unassigned would infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      LOAD:    state_nxt = SHIFT;
      SHIFT:   if (advance && col_last) state_nxt = BLANK;
      BLANK:   state_nxt = LATCH;
      LATCH:   state_nxt = DISPLAY;
      DISPLAY: if (hold_last) state_nxt = row_last ? LOAD : SHIFT;
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      note_r_snap <= '0;
      note_b_snap <= '0;
      offset_snap <= 3'd0;
      row_cnt     <= '0;
      col_cnt     <= '0;
      phase       <= 1'b0;
      div_cnt     <= '0;
      hold_cnt    <= '0;
      row_addr    <= '0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        LOAD: begin
          note_r_snap <= note_R;
          note_b_snap <= note_B;
          offset_snap <= clamp_offset(offset, SLOT_W);
          row_cnt     <= '0;
          col_cnt     <= '0;
          phase       <= 1'b0;
          div_cnt     <= '0;
        end
        SHIFT: begin
          if (div_last) begin
            div_cnt <= '0;
            phase   <= ~phase;
            if (phase) col_cnt <= col_cnt + CA_W'(1);
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        BLANK: begin
          row_addr <= row_cnt;
          hold_cnt <= '0;
          col_cnt  <= '0;
          phase    <= 1'b0;
          div_cnt  <= '0;
        end
        DISPLAY: begin
          if (hold_last) begin
            if (row_last) frame_done <= 1'b1;
            else          row_cnt    <= row_cnt + RA_W'(1);
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // The column generator is preloaded during LOAD, before the snapshot
  // register has taken the new offset, so it is fed the value being captured.
  assign gen_offset = (state == LOAD) ? clamp_offset(offset, SLOT_W) : offset_snap;

  led_col_gen #(
    .NSLOT (NSLOT),
    .SLOT_W(SLOT_W)
  ) u_col_gen (
    .clk        (clk),
    .rst        (rst),
    .start      (state != SHIFT),
    .advance    (advance),
    .offset_snap(gen_offset),
    .lane_blue  (lane_blue),
    .note_r_snap(note_r_snap),
    .note_b_snap(note_b_snap),
    .pixel      (col_bit)
  );

`ifdef FINISH_FLASH_EN
  logic       flash_flag;
  logic [1:0] flash_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flash_flag <= 1'b0;
      flash_cnt  <= 2'd0;
    end else begin
      // A finish landing in the LOAD cycle itself arms the following frame.
      if (finish)              flash_flag <= 1'b1;
      else if (state == LOAD)  flash_flag <= 1'b0;
      // frame_done is high during LOAD, so a fresh load outranks the countdown.
      if (state == LOAD && flash_flag)        flash_cnt <= 2'd3;
      else if (frame_done && flash_cnt != 2'd0) flash_cnt <= flash_cnt - 2'd1;
    end
  end

  assign flash_lit = (flash_cnt != 2'd0);
`else
  wire unused_finish = finish;
  assign flash_lit = 1'b0;
`endif

  assign pixel  = col_bit | flash_lit;
  assign sclk   = (state == SHIFT) && phase;
  assign latch  = (state == LATCH);
  assign oe_n   = (state != DISPLAY);
  assign r_data = (state == SHIFT) && !lane_blue && pixel;
  assign b_data = (state == SHIFT) &&  lane_blue && pixel;

endmodule

// File: tb/tb_led_note_scanner.sv
// -----------------------------------------------------------------------------
// tb_led_note_scanner
// Directed bench for led_note_scanner. Expected rows are computed from the
// note bitmaps with a plain division model and queued before each frame; the
// row watcher pops one entry per scanned row and compares it with the bits
// shifted out on sclk rising edges, plus the panel handshake timing.
// Build option: FINISH_FLASH_EN switches the post-finish frames to flash.
// -----------------------------------------------------------------------------
module tb_led_note_scanner;

  localparam int COLS      = 64;
  localparam int ROWS      = 8;
  localparam int NSLOT     = 10;
  localparam int SLOT_W    = 7;
  localparam int CLK_DIV   = 2;
  localparam int HOLD      = 256;
  localparam int FRAME_CYC = 1 + ROWS * (COLS * 2 * CLK_DIV + 2 + HOLD);
  localparam int GUARD     = 1000;

`ifdef FINISH_FLASH_EN
  localparam bit FLASH = 1'b1;
`else
  localparam bit FLASH = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [NSLOT-1:0] note_R, note_B;
  logic [2:0]       offset;
  logic             finish;
  logic             r_data, b_data, sclk, latch, oe_n, frame_done;
  logic [2:0]       row_addr;

  typedef struct {
    int              row;
    logic [COLS-1:0] r;
    logic [COLS-1:0] b;
  } row_exp_t;

  row_exp_t exp_q[$];
  int       compared   = 0;
  int       mismatched = 0;
  longint   cyc        = 0;
  longint   last_fd    = -1;

  led_note_scanner #(
    .COLS(COLS), .ROWS(ROWS), .NSLOT(NSLOT), .SLOT_W(SLOT_W),
    .CLK_DIV(CLK_DIV), .HOLD(HOLD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .note_R    (note_R),
    .note_B    (note_B),
    .offset    (offset),
    .finish    (finish),
    .r_data    (r_data),
    .b_data    (b_data),
    .sclk      (sclk),
    .latch     (latch),
    .oe_n      (oe_n),
    .row_addr  (row_addr),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic abort_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "run aborted after a bounded wait expired");
  endtask

  // Queue the eight expected rows of one frame.
  task automatic push_frame(input logic [NSLOT-1:0] nr, input logic [NSLOT-1:0] nb,
                            input logic [2:0] off, input bit flash);
    row_exp_t e;
    int       offc, slot;
    logic     lit;
    offc = (int'(off) >= SLOT_W) ? SLOT_W - 1 : int'(off);
    for (int r = 0; r < ROWS; r++) begin
      e.row = r;
      e.r   = '0;
      e.b   = '0;
      for (int c = 0; c < COLS; c++) begin
        slot = (c + offc) / SLOT_W;
        if (flash)              lit = 1'b1;
        else if (slot >= NSLOT) lit = 1'b0;
        else                    lit = (r < ROWS / 2) ? nr[slot] : nb[slot];
        if (r < ROWS / 2) e.r[c] = lit;
        else              e.b[c] = lit;
      end
      exp_q.push_back(e);
    end
  endtask

  // Watch one frame from its LOAD cycle to its frame_done pulse. Optionally
  // drives new inputs (and a finish pulse) at column 10 of row chg_row.
  task automatic watch_frame(input string tag, input int chg_row,
                             input logic [NSLOT-1:0] nr, input logic [NSLOT-1:0] nb,
                             input logic [2:0] off, input logic fin);
    row_exp_t        e;
    bit              changed;
    logic [COLS-1:0] rb, bb;
    int              edges, lat_n, oe_low, guard;
    logic            prev_sclk;
    logic [2:0]      ra;
    bit              ra_bad;
    string           rt;
    changed = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      rt = $sformatf("%s row%0d", tag, r);
      rb = '0; bb = '0; edges = 0; lat_n = 0; oe_low = 0; guard = 0;
      prev_sclk = 1'b0; ra = '0; ra_bad = 1'b0;
      // SHIFT: collect one pixel per sclk rising edge until the latch strobe.
      do begin
        @(negedge clk);
        finish = 1'b0;
        guard++;
        if (!prev_sclk && sclk) begin
          if (edges < COLS) begin
            rb[edges] = r_data;
            bb[edges] = b_data;
          end
          edges++;
        end
        prev_sclk = sclk;
        if (!changed && r == chg_row && edges == 10) begin
          note_R  = nr;
          note_B  = nb;
          offset  = off;
          finish  = fin;
          changed = 1'b1;
        end
      end while (!latch && guard < GUARD);
      if (!latch) begin
        check({rt, " latch wait"}, 64'(latch), 64'd1);
        abort_run();
      end
      lat_n = 1;
      check({rt, " oe_n while latching"}, 64'(oe_n), 64'd1);
      // DISPLAY: count enable-low cycles and watch the row address.
      guard = 0;
      do begin
        @(negedge clk);
        guard++;
        if (latch) lat_n++;
        if (!oe_n) begin
          if (oe_low == 0)          ra = row_addr;
          else if (row_addr !== ra) ra_bad = 1'b1;
          oe_low++;
        end
      end while (!(oe_n && oe_low > 0) && guard < GUARD);
      if (guard >= GUARD) begin
        check({rt, " display wait"}, 64'(oe_low), 64'(HOLD));
        abort_run();
      end
      if (exp_q.size() == 0) begin
        mismatched++;
        $error("FAIL %s scoreboard: observed empty queue expected a queued row", rt);
        abort_run();
      end
      e = exp_q.pop_front();
      check({rt, " r_data bits"},     64'(rb),     64'(e.r));
      check({rt, " b_data bits"},     64'(bb),     64'(e.b));
      check({rt, " sclk rises"},      64'(edges),  64'(COLS));
      check({rt, " latch cycles"},    64'(lat_n),  64'd1);
      check({rt, " oe_n low cycles"}, 64'(oe_low), 64'(HOLD));
      check({rt, " row_addr"},        64'(ra),     64'(e.row));
      check({rt, " row_addr stable"}, 64'(ra_bad), 64'd0);
      check({rt, " frame_done"},      64'(frame_done), 64'(r == ROWS - 1));
      if (r == ROWS - 1) begin
        if (last_fd >= 0) check({tag, " frame length"}, 64'(cyc - last_fd), 64'(FRAME_CYC));
        last_fd = cyc;
      end
    end
  endtask

  initial begin
    int guard;
    rst    = 1'b1;
    note_R = 10'd1;
    note_B = 10'd0;
    offset = 3'd0;
    finish = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values.
    check("reset sclk",       64'(sclk),       64'd0);
    check("reset latch",      64'(latch),      64'd0);
    check("reset oe_n",       64'(oe_n),       64'd1);
    check("reset r_data",     64'(r_data),     64'd0);
    check("reset b_data",     64'(b_data),     64'd0);
    check("reset row_addr",   64'(row_addr),   64'd0);
    check("reset frame_done", 64'(frame_done), 64'd0);

    // Slot 0 red, no offset: columns 0..6 lit on red rows.
    rst = 1'b0;
    push_frame(10'd1, 10'd0, 3'd0, 1'b0);
    watch_frame("f1_slot0", -1, '0, '0, '0, 1'b0);

    // Offset 3 trims slot 0 to columns 0..3.
    offset = 3'd3;
    push_frame(10'd1, 10'd0, 3'd3, 1'b0);
    watch_frame("f2_off3", -1, '0, '0, '0, 1'b0);

    // Blue slot 1: columns 7..13 on blue rows.
    note_R = 10'd0;
    note_B = 10'b10;
    offset = 3'd0;
    push_frame(10'd0, 10'b10, 3'd0, 1'b0);
    watch_frame("f3_blue", -1, '0, '0, '0, 1'b0);

    // Inputs change mid-SHIFT of row 2; this frame keeps the old picture.
    note_R = 10'h155;
    note_B = 10'h2AA;
    offset = 3'd2;
    push_frame(10'h155, 10'h2AA, 3'd2, 1'b0);
    watch_frame("f4_midchange", 2, 10'h201, 10'h200, 3'd7, 1'b0);

    // New picture; offset 7 clamps to 6 (last slot reaches column 63).
    // A finish pulse is given mid-frame.
    push_frame(10'h201, 10'h200, 3'd7, 1'b0);
    watch_frame("f5_clamp", 3, 10'h201, 10'h200, 3'd7, 1'b1);

    for (int f = 0; f < 3; f++) begin
      push_frame(10'h201, 10'h200, 3'd7, FLASH);
      watch_frame($sformatf("f%0d_post_finish", 6 + f), -1, '0, '0, '0, 1'b0);
    end

    push_frame(10'h201, 10'h200, 3'd7, 1'b0);
    watch_frame("f9_after_flash", -1, '0, '0, '0, 1'b0);

    // Reset in the middle of row 5's DISPLAY.
    guard = 0;
    while (!(row_addr == 3'd5 && !oe_n) && guard < 10 * GUARD) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 10 * GUARD) begin
      check("row5 display wait", 64'(row_addr), 64'd5);
      abort_run();
    end
    repeat (100) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("async rst oe_n",       64'(oe_n),       64'd1);
    check("async rst sclk",       64'(sclk),       64'd0);
    check("async rst row_addr",   64'(row_addr),   64'd0);
    check("async rst latch",      64'(latch),      64'd0);
    check("async rst r_data",     64'(r_data),     64'd0);
    check("async rst b_data",     64'(b_data),     64'd0);
    check("async rst frame_done", 64'(frame_done), 64'd0);
    last_fd = -1;
    note_R  = 10'h00F;
    note_B  = 10'h3C0;
    offset  = 3'd4;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    push_frame(10'h00F, 10'h3C0, 3'd4, 1'b0);
    watch_frame("f11_after_reset", -1, '0, '0, '0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
